// File: rtl/nibble_pack_pkg.sv
// Shared types and constants for the two-requester nibble packer.
package nibble_pack_pkg;

  localparam int unsigned NIB_W_DEF = 4;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_C = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StGetHi,
    StGetLo,
    StOut
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the source that did not win last time is chosen.
module rr_arb2
  import nibble_pack_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = SRC_A;
    unique case (req_i)
      2'b01:   gnt_o = SRC_A;
      2'b10:   gnt_o = SRC_C;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = SRC_A;
    endcase
  end

endmodule

// File: rtl/nibble_pack_arb.sv
// Arbitrates requesters A and C onto one nibble-pair-to-byte path with a valid/ready output.
module nibble_pack_arb
  import nibble_pack_pkg::*;
#(
  parameter int unsigned NIB_W = NIB_W_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [NIB_W-1:0]   a_nib,
  output logic               a_ready,
  input  logic               c_valid,
  input  logic [NIB_W-1:0]   c_nib,
  output logic               c_ready,
  output logic               out_valid,
  output logic [2*NIB_W-1:0] out_byte,
  output logic               out_src,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   cnt_a,
  output logic [CNT_W-1:0]   cnt_c
);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic [NIB_W-1:0]   hi_q, hi_d;
  logic [NIB_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_c_q, cnt_c_d;
  logic               pick;
  logic               sel_valid;
  logic [NIB_W-1:0]   sel_nib;

  rr_arb2 u_rr_arb2 (
    .req_i  ({c_valid, a_valid}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Only the granted source is ever looked at once a byte is in progress.
  assign sel_valid = (grant_q == SRC_C) ? c_valid : a_valid;
  assign sel_nib   = (grant_q == SRC_C) ? c_nib : a_nib;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_a_d   = cnt_a_q;
    cnt_c_d   = cnt_c_q;
    a_ready   = 1'b0;
    c_ready   = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (a_valid || c_valid) begin
          grant_d = pick;
          state_d = StGetHi;
        end
      end
      StGetHi: begin
        a_ready = (grant_q == SRC_A);
        c_ready = (grant_q == SRC_C);
        if (sel_valid) begin
          hi_d    = sel_nib;
          state_d = StGetLo;
        end
      end
      StGetLo: begin
        a_ready = (grant_q == SRC_A);
        c_ready = (grant_q == SRC_C);
        if (sel_valid) begin
          lo_d    = sel_nib;
          state_d = StOut;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          last_d = grant_q;
          if (grant_q == SRC_A) begin
            cnt_a_d = cnt_a_q + CNT_W'(1);
          end else begin
            cnt_c_d = cnt_c_q + CNT_W'(1);
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= SRC_A;
      last_q  <= SRC_C;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_a_q <= '0;
      cnt_c_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_a_q <= cnt_a_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  assign out_byte = {hi_q, lo_q};
  assign out_src  = grant_q;
  assign busy     = (state_q != StIdle);
  assign cnt_a    = cnt_a_q;
  assign cnt_c    = cnt_c_q;

endmodule

// File: tb/tb_nibble_pack_arb.sv
// Bench for nibble_pack_arb: transaction-level model compared every cycle plus directed scenarios.
module tb_nibble_pack_arb;

  logic       clk;
  logic       rst;
  logic       a_valid, c_valid, out_ready;
  logic [3:0] a_nib, c_nib;
  logic       a_ready, c_ready, out_valid, out_src, busy;
  logic [7:0] out_byte, cnt_a, cnt_c;

  nibble_pack_arb #(
    .NIB_W (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_nib     (a_nib),
    .a_ready   (a_ready),
    .c_valid   (c_valid),
    .c_nib     (c_nib),
    .c_ready   (c_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy),
    .cnt_a     (cnt_a),
    .cnt_c     (cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner of the byte in progress (-1 none), nibbles collected so far, fairness memory.
  int m_owner = -1;
  int m_nibs[$];
  int m_last = 1;
  int m_cnt_a = 0;
  int m_cnt_c = 0;
  bit m_en = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_owner = -1;
      m_nibs.delete();
      m_last  = 1;
      m_cnt_a = 0;
      m_cnt_c = 0;
    end else if (m_owner < 0) begin
      if (a_valid && c_valid) m_owner = (m_last == 0) ? 1 : 0;
      else if (a_valid) m_owner = 0;
      else if (c_valid) m_owner = 1;
    end else if (m_nibs.size() < 2) begin
      if (m_owner == 0 && a_valid) m_nibs.push_back(int'(a_nib));
      else if (m_owner == 1 && c_valid) m_nibs.push_back(int'(c_nib));
    end else if (out_ready) begin
      if (m_owner == 0) m_cnt_a = (m_cnt_a + 1) % 256;
      else m_cnt_c = (m_cnt_c + 1) % 256;
      m_last  = m_owner;
      m_owner = -1;
      m_nibs.delete();
    end
  end

  bit e_ov;
  always @(negedge clk) begin
    if (m_en) begin
      e_ov = (m_owner >= 0) && (m_nibs.size() == 2);
      chk("busy", busy, m_owner >= 0);
      chk("a_ready", a_ready, m_owner == 0 && m_nibs.size() < 2);
      chk("c_ready", c_ready, m_owner == 1 && m_nibs.size() < 2);
      chk("out_valid", out_valid, e_ov);
      chk("cnt_a", cnt_a, m_cnt_a);
      chk("cnt_c", cnt_c, m_cnt_c);
      if (e_ov) begin
        chk("out_byte", out_byte, m_nibs[0] * 16 + m_nibs[1]);
        chk("out_src", out_src, m_owner);
      end
    end
  end

  // Stimulus state
  int         qa[$];
  int         qc[$];
  logic [7:0] got_byte[$];
  logic       got_src[$];
  int         a_gap = 0;
  int         a_gap_arm = 0;
  bit         rnd_mode = 0;
  int         cr_early = 0;
  bit         ov_seen = 0;

  task automatic drive();
    if (qa.size() > 0 && a_gap == 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
      a_valid = 1'b1;
      a_nib   = 4'(qa[0]);
    end else begin
      a_valid = 1'b0;
      a_nib   = 4'($urandom_range(0, 15));
    end
    if (qc.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
      c_valid = 1'b1;
      c_nib   = 4'(qc[0]);
    end else begin
      c_valid = 1'b0;
      c_nib   = 4'($urandom_range(0, 15));
    end
    if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic tick();
    bit ha, hc, ho;
    @(negedge clk);
    ha = a_valid && a_ready;
    hc = c_valid && c_ready;
    ho = out_valid && out_ready;
    if (out_valid === 1'b1) ov_seen = 1;
    if (c_ready === 1'b1 && got_byte.size() == 0) cr_early++;
    if (ho) begin
      got_byte.push_back(out_byte);
      got_src.push_back(out_src);
    end
    @(posedge clk);
    #1;
    if (a_gap > 0) a_gap--;
    if (ha) begin
      void'(qa.pop_front());
      if (a_gap_arm > 0) begin
        a_gap     = a_gap_arm;
        a_gap_arm = 0;
      end
    end
    if (hc) void'(qc.pop_front());
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    int i;
    i = 0;
    while (got_byte.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (got_byte.size() < n) chk("timeout_bytes", got_byte.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qa.delete();
    qc.delete();
    a_gap     = 0;
    a_gap_arm = 0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    got_byte.delete();
    got_src.delete();
    m_en = 1;
  endtask

  int ea[$];
  int ec[$];
  int ga[$];
  int gc[$];
  int lat;
  int na, nb;

  initial begin
    rst = 1'b1; a_valid = 0; c_valid = 0; a_nib = 0; c_nib = 0; out_ready = 0;
    do_reset();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_out_src", out_src, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_c_ready", c_ready, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_c", cnt_c, 0);

    // Single A byte, latency
    out_ready = 1'b1;
    qa = '{6, 10};
    drive();
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      if (out_valid === 1'b1) lat = i;
      else tick();
    end
    chk("t1_latency", lat, 3);
    run_until(1, 10);
    if (got_byte.size() >= 1) begin
      chk("t1_byte", got_byte[0], 8'h6A);
      chk("t1_src", got_src[0], 0);
    end
    chk("t1_cnt_a", cnt_a, 1);

    // Both valid from reset: A wins first, then C
    do_reset();
    out_ready = 1'b1;
    cr_early  = 0;
    qa = '{6, 10};
    qc = '{1, 15};
    drive();
    run_until(2, 40);
    if (got_byte.size() >= 2) begin
      chk("t2_byte0", got_byte[0], 8'h6A);
      chk("t2_src0", got_src[0], 0);
      chk("t2_byte1", got_byte[1], 8'h1F);
      chk("t2_src1", got_src[1], 1);
    end
    chk("t2_c_ready_during_a", cr_early, 0);

    // Downstream stall in OUT
    got_byte.delete(); got_src.delete();
    out_ready = 1'b0;
    qa = '{5, 2, 7, 7};
    drive();
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_byte", out_byte, 8'h52);
      chk("t3_hold_a_ready", a_ready, 0);
    end
    chk("t3_no_xfer_yet", got_byte.size(), 0);
    out_ready = 1'b1;
    run_until(2, 20);
    if (got_byte.size() >= 2) begin
      chk("t3_byte0", got_byte[0], 8'h52);
      chk("t3_byte1", got_byte[1], 8'h77);
    end

    // A drops valid between nibbles
    got_byte.delete(); got_src.delete();
    qa = '{3, 12};
    a_gap_arm = 4;
    drive();
    run_until(1, 30);
    if (got_byte.size() >= 1) chk("t4_byte", got_byte[0], 8'h3C);

    // Reset in the middle of a byte
    do_reset();
    out_ready = 1'b1;
    qa = '{9};
    drive();
    for (int i = 0; i < 10 && qa.size() > 0; i++) tick();
    tick();
    chk("t5_waiting_lo", a_ready, 1);
    rst = 1'b1;
    ov_seen = 0;
    tick();
    rst = 1'b0;
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_cnt_a", cnt_a, 0);
    qa = '{1, 2};
    drive();
    run_until(1, 20);
    if (got_byte.size() >= 1) chk("t5_clean_byte", got_byte[0], 8'h12);
    chk("t5_cnt_a_after", cnt_a, 1);

    // 256 back-to-back C bytes: counter wraps
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 512; i++) qc.push_back(int'($urandom_range(0, 15)));
    drive();
    run_until(255, 255 * 4 + 40);
    chk("t6_cnt_c_255", cnt_c, 255);
    run_until(256, 20);
    chk("t6_cnt_c_wrap", cnt_c, 0);
    chk("t6_cnt_a", cnt_a, 0);

    // Random traffic, random stalls, random valid drops
    got_byte.delete(); got_src.delete();
    for (int i = 0; i < 30; i++) begin
      na = int'($urandom_range(0, 15)); nb = int'($urandom_range(0, 15));
      qa.push_back(na); qa.push_back(nb); ea.push_back(na * 16 + nb);
      na = int'($urandom_range(0, 15)); nb = int'($urandom_range(0, 15));
      qc.push_back(na); qc.push_back(nb); ec.push_back(na * 16 + nb);
    end
    rnd_mode = 1;
    drive();
    for (int i = 0; i < 4000 && !(qa.size() == 0 && qc.size() == 0 && busy === 1'b0); i++) tick();
    rnd_mode  = 0;
    out_ready = 1'b1;
    chk("t7_total_bytes", got_byte.size(), 60);
    foreach (got_byte[i]) begin
      if (got_src[i] == 1'b0) ga.push_back(int'(got_byte[i]));
      else gc.push_back(int'(got_byte[i]));
    end
    chk("t7_a_count", ga.size(), ea.size());
    chk("t7_c_count", gc.size(), ec.size());
    foreach (ga[i]) if (i < ea.size()) chk("t7_a_order", ga[i], ea[i]);
    foreach (gc[i]) if (i < ec.size()) chk("t7_c_order", gc[i], ec[i]);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
